// File: rtl/dot_pkg.sv
// Shared types and helpers for the streaming dot-product engine.
package dot_pkg;

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, MAC, DONE} state_t;

    localparam int MAX_W = 128;

    function automatic int acc_w(input int data_w, input int len_w);
        return 2 * data_w + len_w;
    endfunction

    // Fill every bit at or above position w with the sign bit (sgn=1) or zero.
    function automatic logic [MAX_W-1:0] extend(input logic [MAX_W-1:0] v,
                                                input int w, input logic sgn);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] sh;
        mask = {MAX_W{1'b1}} << w;
        sh   = v >> (w - 1);
        return (sgn & sh[0]) ? (v | mask) : (v & ~mask);
    endfunction

endpackage

// File: rtl/dot_mac_unit.sv
// Combinational multiply-accumulate step: acc + ext(a*b), with wrap detection.
module dot_mac_unit
    import dot_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int SIGNED = 0
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [ACC_W-1:0]  i_acc,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_ovf
);

    localparam int   PW  = 2 * DATA_W;
    localparam logic SGN = (SIGNED != 0);

    logic [PW-1:0]    w_a_x;
    logic [PW-1:0]    w_b_x;
    logic [PW-1:0]    w_prod;
    logic [ACC_W-1:0] w_addend;
    logic [ACC_W:0]   w_full;
    logic             w_sovf;

    // Operands are pre-extended to 2*DATA_W so one unsigned multiplier
    // yields the correct low bits for both signed and unsigned modes.
    assign w_a_x    = {{DATA_W{SGN & i_a[DATA_W-1]}}, i_a};
    assign w_b_x    = {{DATA_W{SGN & i_b[DATA_W-1]}}, i_b};
    assign w_prod   = w_a_x * w_b_x;
    assign w_addend = ACC_W'(extend(MAX_W'(w_prod), PW, SGN));

    assign w_full = {1'b0, i_acc} + {1'b0, w_addend};
    assign o_sum  = w_full[ACC_W-1:0];
    assign w_sovf = (i_acc[ACC_W-1] == w_addend[ACC_W-1]) &&
                    (o_sum[ACC_W-1] != i_acc[ACC_W-1]);
    assign o_ovf  = SGN ? w_sovf : w_full[ACC_W];

endmodule

// File: rtl/dot_product_engine.sv
// Serial dot-product engine: streams A,B operand pairs over ready/valid and accumulates A*B.
module dot_product_engine
    import dot_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8,
    parameter int ACC_W  = dot_pkg::acc_w(DATA_W, LEN_W),
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic              stop,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  result,
    output logic              done,
    output logic              overflow,
    output logic              busy
);

    state_t             r_state;
    state_t             w_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_result;
    logic [LEN_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic               r_ovf;

    logic               w_in_ready;
    logic               w_xfer;
    logic               w_start_ok;
    logic               w_len_zero;
    logic               w_last;
    logic [ACC_W-1:0]   w_sum;
    logic               w_ovf;

    dot_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_mac (
        .i_a   (r_a),
        .i_b   (r_b),
        .i_acc (r_acc),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    assign w_in_ready = (r_state == LOAD_A) || (r_state == LOAD_B);
    // A transfer coinciding with stop is dropped.
    assign w_xfer     = in_valid && w_in_ready && !stop;
    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_len_zero = (vec_len == '0);
    assign w_last     = (r_cnt == LEN_W'(1));

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_nxt = w_len_zero ? DONE : LOAD_A;
            LOAD_A: begin
                if (stop)        w_nxt = DONE;
                else if (w_xfer) w_nxt = LOAD_B;
            end
            LOAD_B: begin
                if (stop)        w_nxt = DONE;
                else if (w_xfer) w_nxt = MAC;
            end
            MAC:     w_nxt = (w_last || stop) ? DONE : LOAD_A;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_start_ok) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
                r_cnt <= vec_len;
                if (w_len_zero) r_result <= '0;
            end
            case (r_state)
                LOAD_A: begin
                    if (stop) begin
                        r_result <= r_acc;
                        r_a      <= '0;
                    end else if (w_xfer) begin
                        r_a <= data_in;
                    end
                end
                LOAD_B: begin
                    if (stop) begin
                        r_result <= r_acc;
                        r_a      <= '0;
                    end else if (w_xfer) begin
                        r_b <= data_in;
                    end
                end
                MAC: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt - LEN_W'(1);
                    if (w_ovf)         r_ovf    <= 1'b1;
                    if (w_nxt == DONE) r_result <= w_sum;
                end
                default: ;
            endcase
        end
    end

    assign in_ready = w_in_ready;
    assign result   = r_result;
    assign done     = (r_state == DONE);
    assign overflow = r_ovf;
    assign busy     = (r_state != IDLE) && (r_state != DONE);

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed bench for dot_product_engine: default, signed and narrow-accumulator instances.
module tb_dot_product_engine;

    logic       clk;
    logic       rst;
    logic [2:0] start;
    logic [2:0] stop;
    logic [2:0] in_valid;
    logic [7:0] vlen [3];
    logic [7:0] din  [3];
    wire  [2:0] in_ready;
    wire  [2:0] done;
    wire  [2:0] ovf;
    wire  [2:0] busy;
    wire  [23:0] res0;
    wire  [23:0] res1;
    wire  [15:0] res2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_xfer;
    int t_first;
    int done_cyc;

    int va [10] = '{2, 4, 1, 1, 4, 2, 1, 2, 8, 1};
    int vb [10] = '{2, 6, 6, 3, 4, 5, 4, 3, 4, 2};

    dot_product_engine #(.DATA_W(8), .LEN_W(8)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .vec_len(vlen[0]), .stop(stop[0]),
        .data_in(din[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .result(res0), .done(done[0]), .overflow(ovf[0]), .busy(busy[0]));

    dot_product_engine #(.DATA_W(8), .LEN_W(8), .SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .vec_len(vlen[1]), .stop(stop[1]),
        .data_in(din[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .result(res1), .done(done[1]), .overflow(ovf[1]), .busy(busy[1]));

    dot_product_engine #(.DATA_W(8), .LEN_W(8), .ACC_W(16)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .vec_len(vlen[2]), .stop(stop[2]),
        .data_in(din[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .result(res2), .done(done[2]), .overflow(ovf[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input int sel, input logic [7:0] len);
        @(negedge clk);
        start[sel]    = 1'b1;
        vlen[sel]     = len;
        in_valid[sel] = 1'b0;
        @(negedge clk);
        start[sel] = 1'b0;
    endtask

    task automatic send(input int sel, input logic [7:0] v, input bit rnd);
        bit ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            din[sel]      = v;
            in_valid[sel] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_valid[sel] && in_ready[sel]) begin
                ok        = 1'b1;
                last_xfer = cyc;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $error("FAIL send_timeout: sel %0d observed no transfer required one", sel);
        end
    endtask

    task automatic send_vec(input int sel, input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            send(sel, 8'(va[i]), rnd);
            if (i == 0) t_first = last_xfer;
            send(sel, 8'(vb[i]), rnd);
        end
    endtask

    task automatic wait_done(input int sel);
        bit ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            in_valid[sel] = 1'b0;
            if (done[sel]) begin
                ok       = 1'b1;
                done_cyc = cyc;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $error("FAIL done_timeout: sel %0d observed done=0 required 1", sel);
        end
    endtask

    initial begin
        rst = 1'b1; start = '0; stop = '0; in_valid = '0;
        for (int i = 0; i < 3; i++) begin vlen[i] = '0; din[i] = '0; end
        repeat (3) @(negedge clk);
        chk("rst_result", 32'(res0), 0);
        chk("rst_done",   32'(done[0]), 0);
        chk("rst_ovf",    32'(ovf[0]), 0);
        chk("rst_ready",  32'(in_ready[0]), 0);
        chk("rst_busy",   32'(busy[0]), 0);
        rst = 1'b0;

        // vec_len=0 from IDLE completes the next cycle
        go(0, 8'd0);
        chk("len0_idle_done", 32'(done[0]), 1);
        chk("len0_idle_res",  32'(res0), 0);

        // Main stream, in_valid held high
        go(0, 8'd10);
        chk("run_busy", 32'(busy[0]), 1);
        send_vec(0, 10, 1'b0);
        wait_done(0);
        chk("main_result",  32'(res0), 107);
        chk("main_ovf",     32'(ovf[0]), 0);
        chk("main_latency", 32'(done_cyc - t_first), 30);
        chk("main_busy",    32'(busy[0]), 0);

        // Signed (-3,4)(5,-2) = -22
        go(1, 8'd2);
        send(1, 8'hFD, 1'b0); send(1, 8'h04, 1'b0);
        send(1, 8'h05, 1'b0); send(1, 8'hFE, 1'b0);
        wait_done(1);
        chk("signed_result", 32'(res1), 32'h00FF_FFEA);
        chk("signed_ovf",    32'(ovf[1]), 0);

        // 16-bit accumulator wraps
        go(2, 8'd2);
        for (int i = 0; i < 4; i++) send(2, 8'hFF, 1'b0);
        wait_done(2);
        chk("wrap_ovf",    32'(ovf[2]), 1);
        chk("wrap_result", 32'(res2), 64514);

        // Restart from DONE clears done and overflow
        go(2, 8'd1);
        chk("restart_done", 32'(done[2]), 0);
        chk("restart_ovf",  32'(ovf[2]), 0);
        send(2, 8'd3, 1'b0); send(2, 8'd5, 1'b0);
        wait_done(2);
        chk("restart_result", 32'(res2), 15);

        // stop during the MAC after the 4th pair
        go(0, 8'd10);
        send_vec(0, 4, 1'b0);
        @(negedge clk);
        stop[0] = 1'b1; din[0] = 8'd4; in_valid[0] = 1'b1;
        @(negedge clk);
        stop[0] = 1'b0;
        chk("stopmac_done",  32'(done[0]), 1);
        chk("stopmac_res",   32'(res0), 37);
        chk("stopmac_ready", 32'(in_ready[0]), 0);
        repeat (3) @(negedge clk);
        in_valid[0] = 1'b0;
        chk("stopmac_hold", 32'(res0), 37);

        // stop in LOAD_B drops the held A and the same-cycle transfer
        go(0, 8'd3);
        send(0, 8'd3, 1'b0); send(0, 8'd3, 1'b0); send(0, 8'd5, 1'b0);
        @(negedge clk);
        stop[0] = 1'b1; din[0] = 8'd7; in_valid[0] = 1'b1;
        @(negedge clk);
        stop[0] = 1'b0; in_valid[0] = 1'b0;
        chk("stopb_done",  32'(done[0]), 1);
        chk("stopb_res",   32'(res0), 9);
        chk("stopb_ready", 32'(in_ready[0]), 0);

        // vec_len=0 from DONE
        go(0, 8'd0);
        chk("len0_done_done", 32'(done[0]), 1);
        chk("len0_done_res",  32'(res0), 0);

        // start while busy is ignored
        go(0, 8'd2);
        send(0, 8'd1, 1'b0); send(0, 8'd1, 1'b0); send(0, 8'd2, 1'b0);
        @(negedge clk);
        start[0] = 1'b1; vlen[0] = 8'd5; in_valid[0] = 1'b0;
        @(negedge clk);
        start[0] = 1'b0;
        send(0, 8'd2, 1'b0);
        wait_done(0);
        chk("busystart_res", 32'(res0), 5);

        // Random in_valid backpressure
        go(0, 8'd10);
        send_vec(0, 10, 1'b1);
        wait_done(0);
        chk("bp_result", 32'(res0), 107);

        // Reset mid-run
        go(0, 8'd10);
        send_vec(0, 2, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_result", 32'(res0), 0);
        chk("midrst_done",   32'(done[0]), 0);
        chk("midrst_ovf",    32'(ovf[0]), 0);
        chk("midrst_ready",  32'(in_ready[0]), 0);
        chk("midrst_busy",   32'(busy[0]), 0);
        rst = 1'b0;
        in_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_product_engine.md
Name: dot_product_engine

Overview:
- Parametrised successor to the serial dot-product datapath/controlpath pair: computes P = sum(A[i]*B[i]) over a vector streamed one operand per transfer, always A first, then B.
- Adds a ready/valid input handshake, a programmable vector length, a signed mode, early abort, and sticky overflow detection.
- Datapath and FSM are merged into one block, sitting between an operand source (memory reader or testbench) and a result consumer.

Parameters:
- DATA_W, 8, operand width in bits.
- LEN_W, 8, width of the vector-length field; maximum length is 2^LEN_W-1.
- ACC_W, 2*DATA_W+LEN_W, accumulator and result width; may be overridden smaller.
- SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands and result.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; latches vec_len and begins a run.
- vec_len  in  LEN_W  number of A/B pairs, sampled when start is accepted.
- stop  in  1  abort request; ends the run with the partial sum.
- data_in  in  DATA_W  operand stream.
- in_valid  in  1  data_in is valid.
- in_ready  out  1  engine accepts data_in this cycle.
- result  out  ACC_W  dot product, stable while done=1.
- done  out  1  level; result valid.
- overflow  out  1  sticky; accumulator wrapped during this run.
- busy  out  1  high in every state except IDLE and DONE.

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; result, accumulator, pair counter, A register = 0; done=0, overflow=0, in_ready=0, busy=0. Reset wins over every other input, including mid-run; partial sums are discarded.
- IDLE:
  - start=1 and vec_len≠0 → LOAD_A; clear accumulator and overflow; count=vec_len.
  - start=1 and vec_len=0 → DONE with result=0.
- LOAD_A: in_ready=1. A transfer is in_valid && in_ready. On transfer, store A and go to LOAD_B.
- LOAD_B: in_ready=1. On transfer, store B and go to MAC.
- MAC: in_ready=0. acc ← acc + A*B with the product extended to ACC_W (sign-extended if SIGNED, else zero-extended); count ← count-1. count reaches 0 → DONE, else → LOAD_A.
- Throughput: 3 cycles per pair with in_valid held high. Latency from the last B transfer to done=1 is 2 cycles.
- DONE: done=1, result=acc (registered), busy=0. Leaves DONE only on start. start with vec_len≠0 restarts directly into LOAD_A (done drops the next cycle); start with vec_len=0 stays in DONE with result=0.
- stop handling:
  - Sampled in LOAD_A or LOAD_B → DONE next cycle. The held A is discarded; in_ready=0 from that cycle on. A transfer in the same cycle as stop is ignored.
  - stop in MAC → the MAC completes, then DONE.
  - stop in IDLE or DONE is ignored.
- start while busy is ignored.
- Overflow:
  - Unsigned: carry out of the ACC_W-bit add.
  - Signed: both addends have the same sign and the sum sign differs.
  - Sets the sticky flag; the accumulator wraps modulo 2^ACC_W. Cleared only on an accepted start or on rst.
- Products are full 2*DATA_W bits. With the default ACC_W, overflow is unreachable for any vec_len.

Decomposition:
- Package dot_pkg holds:
  - state enum {IDLE, LOAD_A, LOAD_B, MAC, DONE};
  - function acc_w(DATA_W, LEN_W) for the default width;
  - sign/zero-extend helper.
- One natural sub-module, dot_mac_unit: multiply, extend, add and overflow detect, combinational, parametrised by DATA_W/ACC_W/SIGNED. The FSM and registers stay in dot_product_engine.

Test Plan:
- Defaults, vec_len=10, pairs (2,2)(4,6)(1,6)(1,3)(4,4)(2,5)(1,4)(2,3)(8,4)(1,2) with in_valid always 1 → done=1, result=107, overflow=0; 30 cycles from first transfer to done.
- SIGNED=1, DATA_W=8, vec_len=2, pairs (-3,4)(5,-2) → result=-22 (all ones above bit 5), overflow=0.
- DATA_W=8, ACC_W=16, vec_len=2, pairs (255,255)(255,255) → overflow=1, result=64514.
- Same stream as the first test with vec_len=10, stop asserted in the cycle after the 4th B transfer → result=37; in_ready=0 afterwards; remaining data ignored.
- Backpressure/edge: in_valid toggled randomly → same 107; vec_len=0 → done next cycle, result=0; rst mid-run → all outputs 0 the next cycle.
- start during busy → ignored, result unchanged; start in DONE → done drops, overflow clears, new run correct.
